// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer: rebuilds WIDTH-bit words from a start-framed, strobe-qualified,
// MSB-first serial stream into a one-entry valid/ready output buffer.
// Optional feature macro: PARITY_CHK_EN adds a trailing even-parity bit and the parity_err pulse.
module serial_frame_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

`ifdef PARITY_CHK_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             commit;
    logic [WIDTH-1:0] word;
    logic             drain;

    // State and datapath registers; reset discards any partial frame and the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    // Frame FSM: decides next state, shift/count updates and when a word is committed.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        word    = {shreg_q[WIDTH-2:0], sin};
        perr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sin_en && sin) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (sin_en) begin
                    shreg_d = {shreg_q[WIDTH-2:0], sin};
                    if (cnt_q == CntLast) begin
                        // Counter parks at 0 so it never exceeds WIDTH-1.
                        cnt_d = '0;
`ifdef PARITY_CHK_EN
                        state_d = StPar;
`else
                        state_d = StIdle;
                        commit  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_CHK_EN
            StPar: begin
                if (sin_en) begin
                    state_d = StIdle;
                    word    = shreg_q;
                    if (^{shreg_q, sin} == 1'b0) begin
                        commit = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output buffer: drain on handshake; a commit refills it unless full and not draining.
    always_comb begin
        pout_d  = pout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        drain   = valid_q && pout_ready;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (!valid_q || drain) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign pout       = pout_q;
    assign pout_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);
`ifdef PARITY_CHK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (WIDTH=4), scoreboard of expected words.
module tb_serial_frame_deserializer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sin;
    logic             sin_en;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each word consumed by the sink must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && pout_valid && pout_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(pout_valid), 32'd0);
            else chk("word", 32'(pout), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; gap inserts a strobe-less cycle with toggled sin after each non-final bit.
    task automatic send_frame(input logic [WIDTH-1:0] w, input bit gap, input bit ready_last,
                              input bit bad_par);
        logic [WIDTH+1:0] fb;
        int nb;
`ifdef PARITY_CHK_EN
        fb = {1'b1, w, (^w) ^ bad_par};
        nb = WIDTH + 2;
`else
        fb = {1'b0, 1'b1, w};
        nb = WIDTH + 1;
        if (bad_par) fb[WIDTH+1] = 1'b0;
`endif
        for (int i = nb - 1; i >= 0; i--) begin
            if (i == 0 && ready_last) pout_ready = 1'b1;
            sin    = fb[i];
            sin_en = 1'b1;
            tick();
            if (i == nb - 1) chk("busy_after_start", 32'(busy), 32'd1);
            if (i > 0 && gap) begin
                sin_en = 1'b0;
                sin    = ~sin;
                tick();
                chk("busy_gap", 32'(busy), 32'd1);
            end
        end
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, "_pout"}, 32'(pout), 32'd0);
        chk({tag, "_valid"}, 32'(pout_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_perr"}, 32'(parity_err), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        sin        = 1'b0;
        sin_en     = 1'b0;
        pout_ready = 1'b0;
        #12;
        chk("rst_pout", 32'(pout), 32'd0);
        chk("rst_valid", 32'(pout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame 1011 with sink ready.
        pout_ready = 1'b1;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        chk("basic_valid", 32'(pout_valid), 32'd1);
        chk("basic_pout", 32'(pout), 32'hb);
        chk("basic_busy_end", 32'(busy), 32'd0);
        tick();
        chk("basic_valid_clr", 32'(pout_valid), 32'd0);
        chk("basic_pout_kept", 32'(pout), 32'hb);

        // Gapped strobe with toggling sin between samples.
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
        chk("gap_valid", 32'(pout_valid), 32'd1);
        chk("gap_pout", 32'(pout), 32'hb);
        tick();
        chk("gap_valid_clr", 32'(pout_valid), 32'd0);

        // Stall: second word dropped, overrun sticky.
        pout_ready = 1'b0;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        tick();
        send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
        chk("stall_pout", 32'(pout), 32'hb);
        chk("stall_valid", 32'(pout_valid), 32'd1);
        chk("stall_overrun", 32'(overrun), 32'd1);
        tick();
        chk("stall_pout_hold", 32'(pout), 32'hb);
        pout_ready = 1'b1;
        tick();
        chk("stall_valid_clr", 32'(pout_valid), 32'd0);
        chk("stall_overrun_sticky", 32'(overrun), 32'd1);

        do_reset("rst_ovr");

        // Drain and commit on the same edge.
        pout_ready = 1'b0;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b1100);
        send_frame(4'b1100, 1'b0, 1'b1, 1'b0);
        chk("dc_pout", 32'(pout), 32'hc);
        chk("dc_valid", 32'(pout_valid), 32'd1);
        chk("dc_overrun", 32'(overrun), 32'd0);
        tick();
        chk("dc_valid_clr", 32'(pout_valid), 32'd0);

        // Reset mid-frame (start + 2 data bits) with a word still pending.
        pout_ready = 1'b0;
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
        sin_en = 1'b1;
        sin = 1'b1; tick();
        sin = 1'b1; tick();
        sin = 1'b0; tick();
        sin_en = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset("rst_mid");
        pout_ready = 1'b1;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        chk("after_rst_pout", 32'(pout), 32'hb);
        chk("after_rst_valid", 32'(pout_valid), 32'd1);
        chk("after_rst_perr", 32'(parity_err), 32'd0);
        tick();

        // Odd-weight word, then a corrupted-parity frame.
        exp_q.push_back(4'b0111);
        send_frame(4'b0111, 1'b0, 1'b0, 1'b0);
        chk("odd_pout", 32'(pout), 32'h7);
        tick();
`ifdef PARITY_CHK_EN
        send_frame(4'b1011, 1'b0, 1'b0, 1'b1);
        chk("perr_pulse", 32'(parity_err), 32'd1);
        chk("perr_no_valid", 32'(pout_valid), 32'd0);
        chk("perr_pout_kept", 32'(pout), 32'h7);
        tick();
        chk("perr_pulse_end", 32'(parity_err), 32'd0);
`endif
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
